// File: rtl/mem_pkg.sv
// Shared types and helpers for the single-port RMW memory front-end and its
// planned dual-port sibling.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT} state_t;

  typedef struct packed {
    logic full;
    logic nonempty;
  } byte_class_t;

  function automatic int mem_nbytes(input int width);
    return (width + 7) / 8;
  endfunction

  // ext_bits has padding forced to 1, real_bits has padding forced to 0.
  function automatic byte_class_t classify_byte(input logic [7:0] ext_bits,
                                                input logic [7:0] real_bits);
    byte_class_t c;
    c.full     = &ext_bits;
    c.nonempty = |real_bits;
    return c;
  endfunction

endpackage

// File: rtl/mem_byte_classify.sv
// Splits a bit-granular write mask into per-byte full / non-empty flags and
// reports whether any byte is only partly covered.
module mem_byte_classify
  import mem_pkg::*;
#(
  parameter  int DW = 128,
  localparam int NB = mem_nbytes(DW)
) (
  input  logic [DW-1:0] mask,
  output logic [NB-1:0] full,
  output logic [NB-1:0] nonempty,
  output logic          has_partial
);

  logic [NB*8-1:0] ext_mask;
  logic [NB*8-1:0] zext_mask;

  // Padding bits above DW count as set for fullness but never make a byte non-empty.
  always_comb begin
    ext_mask            = '1;
    ext_mask[DW-1:0]    = mask;
    zext_mask           = '0;
    zext_mask[DW-1:0]   = mask;
  end

  for (genvar b = 0; b < NB; b++) begin : g_byte
    byte_class_t cls;
    assign cls         = classify_byte(ext_mask[b*8 +: 8], zext_mask[b*8 +: 8]);
    assign full[b]     = cls.full;
    assign nonempty[b] = cls.nonempty;
  end

  assign has_partial = |(nonempty & ~full);

endmodule

// File: rtl/mem_sp_rmw_ctrl.sv
// Request/response front-end for a single-port byte-enable RAM: byte-covered
// writes go straight through, partial-byte masks become a read-modify-write.
module mem_sp_rmw_ctrl
  import mem_pkg::*;
#(
  parameter  int MEM_DATAWIDTH = 128,
  parameter  int MEM_ADDRWIDTH = 14,
  parameter  int MEM_RD_LAT    = 1,
  parameter  int RMW_EN        = 1,
  localparam int NB            = mem_nbytes(MEM_DATAWIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MEM_DATAWIDTH-1:0] req_we,
  input  logic [MEM_ADDRWIDTH-1:0] req_addr,
  input  logic [MEM_DATAWIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MEM_DATAWIDTH-1:0] rsp_rdata,
  output logic                     ram_en,
  output logic [NB-1:0]            ram_we,
  output logic [MEM_ADDRWIDTH-1:0] ram_addr,
  output logic [MEM_DATAWIDTH-1:0] ram_din,
  input  logic [MEM_DATAWIDTH-1:0] ram_dout
);

  localparam int              CNT_W    = $clog2(MEM_RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [MEM_ADDRWIDTH-1:0]   lat_addr;
  logic [MEM_DATAWIDTH-1:0]   lat_mask;
  logic [MEM_DATAWIDTH-1:0]   lat_wdata;
  logic [NB-1:0]              lat_bytes;

  logic [NB-1:0] full;
  logic [NB-1:0] nonempty;
  logic          has_partial;
  logic          accept;
  logic          is_read;
  logic          is_rmw;
  logic          last;

  mem_byte_classify #(.DW(MEM_DATAWIDTH)) u_classify (
    .mask        (req_we),
    .full        (full),
    .nonempty    (nonempty),
    .has_partial (has_partial)
  );

  // The full-byte vector only matters to the dual-port variant.
  logic unused_full;
  assign unused_full = ^full;

  assign req_ready = ~reset & (state == IDLE) & ~rsp_valid;
  assign accept    = req_valid & req_ready;
  assign is_read   = ~|req_we;
  assign is_rmw    = (RMW_EN != 0) && has_partial;
  assign last      = (cnt == CNT_LAST);

  // RAM strobes are issued in the accept cycle; reset suppresses any pending RMW write.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (!reset) begin
      if (state == IDLE && accept) begin
        ram_en   = 1'b1;
        ram_addr = req_addr;
        if (!is_read && !is_rmw) begin
          ram_we  = nonempty;
          ram_din = req_wdata;
        end
      end else if (state == RMW_WAIT && last) begin
        ram_en   = 1'b1;
        ram_addr = lat_addr;
        ram_we   = lat_bytes;
        ram_din  = (ram_dout & ~lat_mask) | (lat_wdata & lat_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      lat_addr  <= '0;
      lat_mask  <= '0;
      lat_wdata <= '0;
      lat_bytes <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr  <= req_addr;
            lat_mask  <= req_we;
            lat_wdata <= req_wdata;
            lat_bytes <= nonempty;
            if (is_read)     state <= RD_WAIT;
            else if (is_rmw) state <= RMW_WAIT;
          end
        end
        RD_WAIT: begin
          if (last) begin
            rsp_rdata <= ram_dout;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RMW_WAIT: begin
          if (last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sp_rmw_ctrl.sv
// Directed bench: three controller instances (32-bit RMW, 32-bit legacy,
// 12-bit RMW) each backed by a behavioural byte-enable RAM.
module tb_mem_sp_rmw_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        req_valid_a = 0, req_valid_b = 0, req_valid_c = 0;
  logic [31:0] req_we = '0, req_wdata = '0;
  logic [13:0] req_addr = '0;
  logic [11:0] req_we_c = '0, req_wdata_c = '0;
  logic        rsp_ready = 0;

  logic        req_ready_a, rsp_valid_a, ram_en_a;
  logic [31:0] rsp_rdata_a, ram_din_a, ram_dout_a, rd_a1;
  logic [3:0]  ram_we_a;
  logic [13:0] ram_addr_a;
  logic        req_ready_b, rsp_valid_b, ram_en_b;
  logic [31:0] rsp_rdata_b, ram_din_b, ram_dout_b, rd_b1;
  logic [3:0]  ram_we_b;
  logic [13:0] ram_addr_b;
  logic        req_ready_c, rsp_valid_c, ram_en_c;
  logic [11:0] rsp_rdata_c, ram_din_c, ram_dout_c;
  logic [1:0]  ram_we_c;
  logic [13:0] ram_addr_c;

  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];
  logic [11:0] mem_c [0:16383];

  mem_sp_rmw_ctrl #(.MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(14), .MEM_RD_LAT(2), .RMW_EN(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_din(ram_din_a), .ram_dout(ram_dout_a));

  mem_sp_rmw_ctrl #(.MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(14), .MEM_RD_LAT(2), .RMW_EN(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_din(ram_din_b), .ram_dout(ram_dout_b));

  mem_sp_rmw_ctrl #(.MEM_DATAWIDTH(12), .MEM_ADDRWIDTH(14), .MEM_RD_LAT(1), .RMW_EN(1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid_c), .req_ready(req_ready_c),
    .req_we(req_we_c), .req_addr(req_addr), .req_wdata(req_wdata_c),
    .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_c),
    .ram_en(ram_en_c), .ram_we(ram_we_c), .ram_addr(ram_addr_c),
    .ram_din(ram_din_c), .ram_dout(ram_dout_c));

  // Byte-enable RAMs: two-stage read pipeline for A/B, one stage for C.
  always @(posedge clk) begin
    if (ram_en_a) begin
      rd_a1 <= mem_a[ram_addr_a];
      for (int i = 0; i < 4; i++)
        if (ram_we_a[i]) mem_a[ram_addr_a][i*8 +: 8] <= ram_din_a[i*8 +: 8];
    end
    ram_dout_a <= rd_a1;
  end

  always @(posedge clk) begin
    if (ram_en_b) begin
      rd_b1 <= mem_b[ram_addr_b];
      for (int i = 0; i < 4; i++)
        if (ram_we_b[i]) mem_b[ram_addr_b][i*8 +: 8] <= ram_din_b[i*8 +: 8];
    end
    ram_dout_b <= rd_b1;
  end

  always @(posedge clk) begin
    if (ram_en_c) begin
      ram_dout_c <= mem_c[ram_addr_c];
      if (ram_we_c[0]) mem_c[ram_addr_c][7:0]  <= ram_din_c[7:0];
      if (ram_we_c[1]) mem_c[ram_addr_c][11:8] <= ram_din_c[11:8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a read on the selected instance and waits (bounded) for its response.
  task automatic do_read(input int sel, input logic [13:0] addr,
                         output logic [31:0] data, output bit ok);
    ok = 0;
    data = '0;
    req_addr = addr;
    rsp_ready = 1;
    case (sel)
      0: begin req_valid_a = 1; req_we = '0; end
      1: begin req_valid_b = 1; req_we = '0; end
      default: begin req_valid_c = 1; req_we_c = '0; end
    endcase
    step();
    req_valid_a = 0; req_valid_b = 0; req_valid_c = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      case (sel)
        0: if (rsp_valid_a) begin ok = 1; data = rsp_rdata_a; end
        1: if (rsp_valid_b) begin ok = 1; data = rsp_rdata_b; end
        default: if (rsp_valid_c) begin ok = 1; data = {20'h0, rsp_rdata_c}; end
      endcase
      step();
    end
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    reset = 0;
    #1;
    n_checks++;
    if ({req_ready_a, rsp_valid_a, ram_en_a} !== 3'b100) begin
      n_errors++; $display("[TB] FAIL reset_ctl got=%b exp=100", {req_ready_a, rsp_valid_a, ram_en_a});
    end
    n_checks++;
    if ({rsp_rdata_a, ram_we_a, ram_addr_a, ram_din_a} !== '0) begin
      n_errors++; $display("[TB] FAIL reset_data rdata=%h we=%h addr=%h din=%h exp=0",
                           rsp_rdata_a, ram_we_a, ram_addr_a, ram_din_a);
    end
    n_checks++;
    if ({req_ready_c, rsp_valid_c, ram_en_c, ram_we_c} !== 5'b10000) begin
      n_errors++; $display("[TB] FAIL reset_c got=%b exp=10000", {req_ready_c, rsp_valid_c, ram_en_c, ram_we_c});
    end
    step();
  endtask

  task automatic test_direct_write();
    req_valid_a = 1; req_we = 32'hFFFF_FFFF; req_addr = 14'd5; req_wdata = 32'hAABB_CCDD;
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a, ram_we_a} !== 6'b11_1111) begin
      n_errors++; $display("[TB] FAIL dw_strobe got=%b exp=111111", {req_ready_a, ram_en_a, ram_we_a});
    end
    n_checks++;
    if ({ram_addr_a, ram_din_a} !== {14'd5, 32'hAABB_CCDD}) begin
      n_errors++; $display("[TB] FAIL dw_addr_din addr=%h din=%h exp=5/aabbccdd", ram_addr_a, ram_din_a);
    end
    step();
    req_valid_a = 0;
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a} !== 2'b10) begin
      n_errors++; $display("[TB] FAIL dw_after got=%b exp=10", {req_ready_a, ram_en_a});
    end
    step();
  endtask

  task automatic test_read_latency();
    rsp_ready = 0;
    req_valid_a = 1; req_we = '0; req_addr = 14'd5;
    #1;
    n_checks++;
    if ({ram_en_a, ram_we_a, ram_addr_a} !== {1'b1, 4'h0, 14'd5}) begin
      n_errors++; $display("[TB] FAIL rd_issue en=%b we=%h addr=%h exp=1/0/5", ram_en_a, ram_we_a, ram_addr_a);
    end
    step();
    req_valid_a = 0;
    #1;
    n_checks++;
    if ({req_ready_a, rsp_valid_a, ram_en_a} !== 3'b000) begin
      n_errors++; $display("[TB] FAIL rd_t1 got=%b exp=000", {req_ready_a, rsp_valid_a, ram_en_a});
    end
    step();
    #1;
    n_checks++;
    if (rsp_valid_a !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rd_t2_early got=%b exp=0", rsp_valid_a);
    end
    step();
    #1;
    n_checks++;
    if ({rsp_valid_a, req_ready_a, rsp_rdata_a} !== {2'b10, 32'hAABB_CCDD}) begin
      n_errors++; $display("[TB] FAIL rd_t3 valid=%b ready=%b data=%h exp=1/0/aabbccdd",
                           rsp_valid_a, req_ready_a, rsp_rdata_a);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1;
    n_checks++;
    if ({rsp_valid_a, req_ready_a} !== 2'b01) begin
      n_errors++; $display("[TB] FAIL rd_t4 got=%b exp=01", {rsp_valid_a, req_ready_a});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit ok;
    req_valid_a = 1; req_we = 32'hFFFF_FFFF; req_addr = 14'd1; req_wdata = 32'h1111_1111;
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a, ram_addr_a} !== {2'b11, 14'd1}) begin
      n_errors++; $display("[TB] FAIL b2b_first got=%b/%h exp=11/1", {req_ready_a, ram_en_a}, ram_addr_a);
    end
    step();
    req_addr = 14'd2; req_wdata = 32'h2222_2222;
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a, ram_addr_a, ram_din_a} !== {2'b11, 14'd2, 32'h2222_2222}) begin
      n_errors++; $display("[TB] FAIL b2b_second got=%b/%h/%h exp=11/2/22222222",
                           {req_ready_a, ram_en_a}, ram_addr_a, ram_din_a);
    end
    step();
    req_valid_a = 0;
    do_read(0, 14'd1, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1111_1111) begin
      n_errors++; $display("[TB] FAIL b2b_rd1 ok=%0d got=%h exp=11111111", ok, d);
    end
    do_read(0, 14'd2, d, ok);
    n_checks++;
    if (!ok || d !== 32'h2222_2222) begin
      n_errors++; $display("[TB] FAIL b2b_rd2 ok=%0d got=%h exp=22222222", ok, d);
    end
  endtask

  task automatic test_rmw();
    logic [31:0] d;
    bit ok;
    req_valid_a = 1; req_we = 32'hFFFF_FFFF; req_addr = 14'd7; req_wdata = 32'h1234_5678;
    step();
    req_we = 32'h0000_00F0; req_wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if ({ram_en_a, ram_we_a, ram_addr_a} !== {1'b1, 4'h0, 14'd7}) begin
      n_errors++; $display("[TB] FAIL rmw_read en=%b we=%h addr=%h exp=1/0/7", ram_en_a, ram_we_a, ram_addr_a);
    end
    step();
    req_valid_a = 0;
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a} !== 2'b00) begin
      n_errors++; $display("[TB] FAIL rmw_t1 got=%b exp=00", {req_ready_a, ram_en_a});
    end
    step();
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a, ram_we_a} !== 6'b01_0001) begin
      n_errors++; $display("[TB] FAIL rmw_t2_strobe got=%b exp=010001", {req_ready_a, ram_en_a, ram_we_a});
    end
    n_checks++;
    if ({ram_addr_a, ram_din_a} !== {14'd7, 32'h1234_56F8}) begin
      n_errors++; $display("[TB] FAIL rmw_t2_din addr=%h din=%h exp=7/123456f8", ram_addr_a, ram_din_a);
    end
    step();
    #1;
    n_checks++;
    if ({req_ready_a, ram_en_a} !== 2'b10) begin
      n_errors++; $display("[TB] FAIL rmw_t3 got=%b exp=10", {req_ready_a, ram_en_a});
    end
    step();
    do_read(0, 14'd7, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1234_56F8) begin
      n_errors++; $display("[TB] FAIL rmw_readback ok=%0d got=%h exp=123456f8", ok, d);
    end
  endtask

  task automatic test_legacy();
    logic [31:0] d;
    bit ok;
    req_valid_b = 1; req_we = 32'hFFFF_FFFF; req_addr = 14'd7; req_wdata = 32'h1234_5678;
    step();
    req_we = 32'h0000_00F0; req_wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if ({ram_en_b, ram_we_b, ram_din_b} !== {1'b1, 4'h1, 32'hFFFF_FFFF}) begin
      n_errors++; $display("[TB] FAIL legacy_write en=%b we=%h din=%h exp=1/1/ffffffff", ram_en_b, ram_we_b, ram_din_b);
    end
    step();
    req_valid_b = 0;
    #1;
    n_checks++;
    if ({req_ready_b, ram_en_b} !== 2'b10) begin
      n_errors++; $display("[TB] FAIL legacy_after got=%b exp=10", {req_ready_b, ram_en_b});
    end
    step();
    do_read(1, 14'd7, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1234_56FF) begin
      n_errors++; $display("[TB] FAIL legacy_readback ok=%0d got=%h exp=123456ff", ok, d);
    end
  endtask

  task automatic test_narrow();
    logic [31:0] d;
    bit ok;
    req_valid_c = 1; req_we_c = 12'hFFF; req_addr = 14'd3; req_wdata_c = 12'h5A5;
    step();
    req_we_c = 12'hF00; req_wdata_c = 12'hABC;
    #1;
    n_checks++;
    if ({ram_en_c, ram_we_c, ram_din_c} !== {1'b1, 2'b10, 12'hABC}) begin
      n_errors++; $display("[TB] FAIL narrow_pad en=%b we=%b din=%h exp=1/10/abc", ram_en_c, ram_we_c, ram_din_c);
    end
    step();
    req_we_c = 12'h300; req_wdata_c = 12'h1FF;
    #1;
    n_checks++;
    if ({req_ready_c, ram_en_c, ram_we_c} !== 4'b1100) begin
      n_errors++; $display("[TB] FAIL narrow_rmw_read got=%b exp=1100", {req_ready_c, ram_en_c, ram_we_c});
    end
    step();
    req_valid_c = 0;
    #1;
    n_checks++;
    if ({req_ready_c, ram_en_c, ram_we_c, ram_din_c} !== {4'b0110, 12'h9A5}) begin
      n_errors++; $display("[TB] FAIL narrow_rmw_write ctl=%b din=%h exp=0110/9a5",
                           {req_ready_c, ram_en_c, ram_we_c}, ram_din_c);
    end
    step();
    #1;
    n_checks++;
    if ({req_ready_c, ram_en_c} !== 2'b10) begin
      n_errors++; $display("[TB] FAIL narrow_rmw_done got=%b exp=10", {req_ready_c, ram_en_c});
    end
    step();
    do_read(2, 14'd3, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_09A5) begin
      n_errors++; $display("[TB] FAIL narrow_readback ok=%0d got=%h exp=9a5", ok, d);
    end
  endtask

  task automatic test_rsp_hold();
    bit seen = 0;
    rsp_ready = 0;
    req_valid_a = 1; req_we = '0; req_addr = 14'd5;
    step();
    req_valid_a = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (rsp_valid_a) seen = 1;
      else step();
    end
    n_checks++;
    if (!seen) begin
      n_errors++; $display("[TB] FAIL hold_rsp_timeout got=0 exp=1");
    end
    req_valid_a = 1; req_we = 32'hFFFF_FFFF; req_addr = 14'd9; req_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({rsp_valid_a, rsp_rdata_a, req_ready_a, ram_en_a} !== {1'b1, 32'hAABB_CCDD, 2'b00}) begin
        n_errors++; $display("[TB] FAIL hold_cycle%0d valid=%b data=%h ready=%b en=%b exp=1/aabbccdd/0/0",
                             i, rsp_valid_a, rsp_rdata_a, req_ready_a, ram_en_a);
      end
      step();
    end
    rsp_ready = 1;
    #1;
    n_checks++;
    if ({rsp_valid_a, req_ready_a, ram_en_a} !== 3'b100) begin
      n_errors++; $display("[TB] FAIL hold_handshake got=%b exp=100", {rsp_valid_a, req_ready_a, ram_en_a});
    end
    step();
    rsp_ready = 0;
    #1;
    n_checks++;
    if ({rsp_valid_a, req_ready_a, ram_en_a, ram_addr_a} !== {3'b011, 14'd9}) begin
      n_errors++; $display("[TB] FAIL hold_accept got=%b/%h exp=011/9", {rsp_valid_a, req_ready_a, ram_en_a}, ram_addr_a);
    end
    step();
    req_valid_a = 0;
  endtask

  task automatic test_reset_rmw();
    logic [31:0] d;
    bit ok;
    req_valid_a = 1; req_we = 32'h0000_0F00; req_addr = 14'd7; req_wdata = 32'h0;
    #1;
    n_checks++;
    if ({ram_en_a, ram_we_a} !== 5'b10000) begin
      n_errors++; $display("[TB] FAIL rst_rmw_read got=%b exp=10000", {ram_en_a, ram_we_a});
    end
    step();
    req_valid_a = 0;
    reset = 1;
    #1;
    n_checks++;
    if (ram_en_a !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rst_rmw_t1 en=%b exp=0", ram_en_a);
    end
    step();
    reset = 0;
    #1;
    n_checks++;
    if ({req_ready_a, rsp_valid_a, ram_en_a, ram_we_a, ram_addr_a, ram_din_a, rsp_rdata_a} !== {3'b100, 82'h0}) begin
      n_errors++; $display("[TB] FAIL rst_rmw_state ctl=%b we=%h din=%h rdata=%h exp=100/0/0/0",
                           {req_ready_a, rsp_valid_a, ram_en_a}, ram_we_a, ram_din_a, rsp_rdata_a);
    end
    step();
    #1;
    n_checks++;
    if (ram_en_a !== 1'b0) begin
      n_errors++; $display("[TB] FAIL rst_rmw_late_write en=%b exp=0", ram_en_a);
    end
    step();
    do_read(0, 14'd7, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1234_56F8) begin
      n_errors++; $display("[TB] FAIL rst_rmw_mem ok=%0d got=%h exp=123456f8", ok, d);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_read_latency();
    test_back_to_back();
    test_rmw();
    test_legacy();
    test_narrow();
    test_rsp_hold();
    test_reset_rmw();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
